// File: rtl/sb_pkg.sv
// Shared scoreboard types: pipeline table entry, forward-select encoding, stage indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sb_pkg;

    localparam int NREG  = 32;              // architectural registers, reg 0 hardwired zero
    localparam int DEPTH = 3;               // stages from issue to writeback
    localparam int AW    = $clog2(NREG);
    localparam int LW    = $clog2(DEPTH);
    localparam int SW    = $clog2(DEPTH + 1);

    // Forward-select encoding: 0 reads the regfile, k forwards from stage k-1.
    localparam logic [SW-1:0] FWD_RF = '0;

    // Stage indices, shared with the datapath forward muxes.
    localparam int ST_EX  = 0;
    localparam int ST_MEM = 1;
    localparam int ST_WB  = DEPTH - 1;

    typedef struct packed {
        logic          v;    // stage holds a live register write
        logic [AW-1:0] rd;   // destination register
        logic [LW-1:0] lat;  // first stage whose output carries the result
    } sb_entry_t;

endpackage

// File: rtl/scoreboard_fwd_if.sv
// ID-stage <-> scoreboard signal bundle.
// Latency: n/a (wiring only).
// Backpressure: id_stall is the hold signal back to ID.
// master = ID stage side (drives instruction info), slave = scoreboard.
interface scoreboard_fwd_if;
    import sb_pkg::*;

    logic            id_valid;
    logic            pipe_adv;
    logic            flush;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            rf_wen;
    logic [LW-1:0]   lat;
    logic            is_long;
    logic            lwb_valid;
    logic [AW-1:0]   lwb_rd;
    logic            id_stall;
    logic            issue_fire;
    logic [SW-1:0]   fwd1_sel;
    logic [SW-1:0]   fwd2_sel;
    logic [NREG-1:0] busy;

    modport master (
        output id_valid, pipe_adv, flush, rs1, rs2, rd, rf_wen, lat, is_long,
               lwb_valid, lwb_rd,
        input  id_stall, issue_fire, fwd1_sel, fwd2_sel, busy
    );

    modport slave (
        input  id_valid, pipe_adv, flush, rs1, rs2, rd, rf_wen, lat, is_long,
               lwb_valid, lwb_rd,
        output id_stall, issue_fire, fwd1_sel, fwd2_sel, busy
    );

endinterface

// File: rtl/sb_src_match.sv
// Priority match of one source register against the stage table.
// Latency: combinational.
// Backpressure: none; ready=0 tells the top the operand must stall.
// Ports: rs (source reg), ent (stage table), hit (some stage writes rs),
//        ready (youngest writer's result already produced), sel (k+1 of youngest writer).
module sb_src_match
    import sb_pkg::*;
(
    input  logic [AW-1:0] rs,
    input  sb_entry_t     ent [DEPTH],
    output logic          hit,
    output logic          ready,
    output logic [SW-1:0] sel
);

    always_comb begin
        hit   = 1'b0;
        ready = 1'b1;
        sel   = FWD_RF;
        // Scan oldest to youngest so the youngest matching stage wins.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rs != '0 && ent[k].v && ent[k].rd == rs) begin
                hit   = 1'b1;
                ready = (LW'(k) >= ent[k].lat);
                sel   = SW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/scoreboard_fwd.sv
// Stage-indexed hazard scoreboard with forwarding select, beside the ID stage.
// Latency: id_stall/issue_fire/fwd*_sel combinational from the table; busy registered.
// Backpressure: asserts id_stall to hold ID; pipe_adv=0 freezes the stage table.
// Ports: clk, rst (sync, active-high), sb (slave side of scoreboard_fwd_if).
module scoreboard_fwd
    import sb_pkg::*;
#(
    parameter int FLUSH_STAGES = 1
) (
    input  logic            clk,
    input  logic            rst,
    scoreboard_fwd_if.slave sb
);

    sb_entry_t       e [DEPTH];
    sb_entry_t       ent_new;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    logic            hit1, rdy1, hit2, rdy2;
    logic [SW-1:0]   sel1, sel2;
    logic            stall1, stall2, waw_stall;
    logic            id_stall;
    logic            issue_fire;

    sb_src_match u_match1 (.rs(sb.rs1), .ent(e), .hit(hit1), .ready(rdy1), .sel(sel1));
    sb_src_match u_match2 (.rs(sb.rs2), .ent(e), .hit(hit2), .ready(rdy2), .sel(sel2));

    // A stage hit decides on its own; the busy map only matters when no stage writes rs.
    assign stall1    = hit1 ? !rdy1 : (sb.rs1 != '0 && busy_q[sb.rs1]);
    assign stall2    = hit2 ? !rdy2 : (sb.rs2 != '0 && busy_q[sb.rs2]);
    // WAW against a pending long op: the later writer must not overtake it.
    assign waw_stall = sb.rf_wen && sb.rd != '0 && busy_q[sb.rd];

    assign id_stall   = sb.id_valid && (stall1 || stall2 || waw_stall);
    assign issue_fire = sb.id_valid && sb.pipe_adv && !id_stall && !sb.flush;

    assign sb.id_stall   = id_stall;
    assign sb.issue_fire = issue_fire;
    assign sb.fwd1_sel   = (hit1 && rdy1) ? sel1 : FWD_RF;
    assign sb.fwd2_sel   = (hit2 && rdy2) ? sel2 : FWD_RF;
    assign sb.busy       = busy_q;

    always_comb begin
        ent_new = '0;
        if (issue_fire && sb.rf_wen && sb.rd != '0 && !sb.is_long) begin
            ent_new.v   = 1'b1;
            ent_new.rd  = sb.rd;
            ent_new.lat = sb.lat;
        end
    end

    // Clear before set so a same-cycle reissue of the register stays busy.
    always_comb begin
        busy_nxt = busy_q;
        if (sb.lwb_valid && sb.lwb_rd != '0) begin
            busy_nxt[sb.lwb_rd] = 1'b0;
        end
        if (issue_fire && sb.rf_wen && sb.is_long && sb.rd != '0) begin
            busy_nxt[sb.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                e[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (sb.pipe_adv) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    e[k] <= e[k - 1];
                end
                e[0] <= ent_new;
            end
            // Later assignment overrides the shift: young stages die after the edge.
            if (sb.flush) begin
                for (int k = 0; k < FLUSH_STAGES; k++) begin
                    e[k].v <= 1'b0;
                end
            end
            busy_q <= busy_nxt;
        end
    end

    lat_legal: assert property (@(posedge clk) disable iff (rst)
        (sb.id_valid && sb.rf_wen && !sb.is_long) |-> (int'(sb.lat) < DEPTH));

endmodule

// File: tb/tb_scoreboard_fwd.sv
// Bench for scoreboard_fwd: directed hazard scenarios plus random traffic against a
// list-of-in-flight-writes reference model; expectations queued, checked at negedge.
module tb_scoreboard_fwd;
    import sb_pkg::*;

    localparam int FL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scoreboard_fwd_if sbif ();
    scoreboard_fwd #(.FLUSH_STAGES(FL)) dut (.clk(clk), .rst(rst), .sb(sbif));

    typedef struct { int rd; int lat; int stage; } wr_t;
    typedef struct { bit stall; bit fire; int s1; int s2; logic [NREG-1:0] busy; } exp_t;

    wr_t  infl[$];
    bit   busy_m [NREG];
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // stimulus for the current cycle
    bit s_rst, s_v, s_adv, s_fl, s_wen, s_lng, s_lwbv;
    int s_r1, s_r2, s_rd, s_lt, s_lwbr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    // Youngest in-flight writer decides; otherwise the long-op busy map.
    function automatic void lookup(input int rs, output bit st, output int sel);
        int best = -1;
        int blat = 0;
        st  = 1'b0;
        sel = 0;
        if (rs == 0) return;
        foreach (infl[i]) begin
            if (infl[i].rd == rs && (best < 0 || infl[i].stage < best)) begin
                best = infl[i].stage;
                blat = infl[i].lat;
            end
        end
        if (best >= 0) begin
            if (best >= blat) sel = best + 1;
            else begin st = 1'b1; sel = -1; end
        end else if (busy_m[rs]) begin
            st = 1'b1; sel = -1;
        end
    endfunction

    task automatic idle();
        s_rst = 0; s_v = 0; s_adv = 1; s_fl = 0; s_wen = 0; s_lng = 0; s_lwbv = 0;
        s_r1 = 0; s_r2 = 0; s_rd = 0; s_lt = 0; s_lwbr = 0;
    endtask

    task automatic ins(input int r1, input int r2, input int rd, input bit wen,
                       input int lt, input bit lng);
        idle();
        s_v = 1; s_r1 = r1; s_r2 = r2; s_rd = rd; s_wen = wen; s_lt = lt; s_lng = lng;
    endtask

    // Apply stimulus after the edge, queue expected outputs, advance the model.
    task automatic step(input bit check);
        exp_t x;
        bit st1, st2;
        int sel1, sel2;
        wr_t nq[$];
        @(posedge clk); #1;
        rst            = s_rst;
        sbif.id_valid  = s_v;
        sbif.pipe_adv  = s_adv;
        sbif.flush     = s_fl;
        sbif.rs1       = AW'(s_r1);
        sbif.rs2       = AW'(s_r2);
        sbif.rd        = AW'(s_rd);
        sbif.rf_wen    = s_wen;
        sbif.lat       = LW'(s_lt);
        sbif.is_long   = s_lng;
        sbif.lwb_valid = s_lwbv;
        sbif.lwb_rd    = AW'(s_lwbr);
        #1;
        lookup(s_r1, st1, sel1);
        lookup(s_r2, st2, sel2);
        x.stall = s_v && (st1 || st2 || (s_wen && s_rd != 0 && busy_m[s_rd]));
        x.fire  = s_v && s_adv && !x.stall && !s_fl;
        x.s1    = sel1;
        x.s2    = sel2;
        for (int i = 0; i < NREG; i++) x.busy[i] = busy_m[i];
        if (check) exp_q.push_back(x);

        if (s_rst) begin
            infl.delete();
            foreach (busy_m[i]) busy_m[i] = 0;
        end else begin
            if (s_adv) begin
                foreach (infl[i])
                    if (infl[i].stage + 1 < DEPTH)
                        nq.push_back('{infl[i].rd, infl[i].lat, infl[i].stage + 1});
                if (x.fire && s_wen && s_rd != 0 && !s_lng) nq.push_back('{s_rd, s_lt, 0});
                infl = nq;
            end
            if (s_fl) begin
                nq.delete();
                foreach (infl[i]) if (infl[i].stage >= FL) nq.push_back(infl[i]);
                infl = nq;
            end
            if (s_lwbv && s_lwbr != 0) busy_m[s_lwbr] = 0;
            if (x.fire && s_wen && s_lng && s_rd != 0) busy_m[s_rd] = 1;
        end
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 1) step(1);
    endtask

    // Monitor: compares DUT outputs with queued expectations mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("id_stall", 32'(sbif.id_stall), 32'(x.stall));
                chk("issue_fire", 32'(sbif.issue_fire), 32'(x.fire));
                if (x.s1 >= 0) chk("fwd1_sel", 32'(sbif.fwd1_sel), 32'(x.s1));
                if (x.s2 >= 0) chk("fwd2_sel", 32'(sbif.fwd2_sel), 32'(x.s2));
                chk("busy", sbif.busy, x.busy);
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        sbif.id_valid = 0; sbif.pipe_adv = 0; sbif.flush = 0;
        sbif.rs1 = '0; sbif.rs2 = '0; sbif.rd = '0; sbif.rf_wen = 0; sbif.lat = '0;
        sbif.is_long = 0; sbif.lwb_valid = 0; sbif.lwb_rd = '0;
        idle(); s_rst = 1;
        step(0); step(0);
        idle();
        step(1);
        chk("reset_stall", 32'(sbif.id_stall), 32'd0);
        chk("reset_busy", sbif.busy, 32'd0);

        // 1: ALU result forwarded from EX, then from the next stage
        ins(0, 0, 5, 1, 0, 0); step(1);
        ins(5, 0, 0, 0, 0, 0); step(1);
        chk("alu_fwd_ex", 32'(sbif.fwd1_sel), 32'd1);
        chk("alu_nostall", 32'(sbif.id_stall), 32'd0);
        step(1);
        chk("alu_fwd_mem", 32'(sbif.fwd1_sel), 32'd2);
        drain();

        // 2: load-use costs one stall cycle
        ins(0, 0, 6, 1, 1, 0); step(1);
        ins(0, 6, 0, 0, 0, 0); step(1);
        chk("load_use_stall", 32'(sbif.id_stall), 32'd1);
        step(1);
        chk("load_use_resume", 32'(sbif.id_stall), 32'd0);
        chk("load_fwd", 32'(sbif.fwd2_sel), 32'd2);
        chk("load_fire", 32'(sbif.issue_fire), 32'd1);
        drain();

        // 3: youngest writer wins
        ins(0, 0, 7, 1, 0, 0); step(1);
        ins(0, 0, 3, 1, 0, 0); step(1);
        ins(0, 0, 7, 1, 0, 0); step(1);
        ins(7, 0, 0, 0, 0, 0); step(1);
        chk("youngest_wins", 32'(sbif.fwd1_sel), 32'd1);
        drain();

        // 4: long op busy, consumer resumes after writeback, set beats clear
        ins(0, 0, 8, 1, 0, 1); step(1);
        ins(8, 0, 0, 0, 0, 0); step(1);
        chk("long_stall", 32'(sbif.id_stall), 32'd1);
        chk("long_busy", 32'(sbif.busy[8]), 32'd1);
        s_lwbv = 1; s_lwbr = 8; step(1);
        chk("long_wb_cycle_stall", 32'(sbif.id_stall), 32'd1);
        ins(8, 0, 0, 0, 0, 0); step(1);
        chk("long_resume", 32'(sbif.id_stall), 32'd0);
        ins(0, 0, 8, 1, 0, 1); s_lwbv = 1; s_lwbr = 8; step(1);
        chk("long_reissue_fire", 32'(sbif.issue_fire), 32'd1);
        idle(); step(1);
        chk("set_beats_clear", 32'(sbif.busy[8]), 32'd1);
        s_lwbv = 1; s_lwbr = 8; step(1);
        drain();

        // 5: frozen flush kills the EX entry
        ins(0, 0, 9, 1, 0, 0); step(1);
        idle(); s_adv = 0; s_fl = 1; step(1);
        ins(9, 0, 0, 0, 0, 0); step(1);
        chk("flush_sel", 32'(sbif.fwd1_sel), 32'd0);
        chk("flush_nostall", 32'(sbif.id_stall), 32'd0);
        drain();

        // 6: x0, freeze, reset mid-flight
        ins(0, 0, 0, 1, 0, 0); step(1);
        ins(0, 0, 0, 0, 0, 0); step(1);
        chk("x0_sel", 32'(sbif.fwd1_sel), 32'd0);
        chk("x0_stall", 32'(sbif.id_stall), 32'd0);
        ins(0, 0, 10, 1, 0, 0); step(1);
        for (int i = 0; i < 3; i++) begin
            ins(10, 0, 0, 0, 0, 0); s_adv = 0; step(1);
            chk("freeze_sel", 32'(sbif.fwd1_sel), 32'd1);
        end
        ins(0, 0, 11, 1, 0, 1); step(1);
        ins(0, 0, 12, 1, 1, 0); step(1);
        idle(); s_rst = 1; step(1);
        ins(11, 12, 0, 0, 0, 0); step(1);
        chk("rst_busy", sbif.busy, 32'd0);
        chk("rst_sel", 32'(sbif.fwd2_sel), 32'd0);
        chk("rst_stall", 32'(sbif.id_stall), 32'd0);

        // random traffic on a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            idle();
            s_rst  = ($urandom_range(0, 99) == 0);
            s_v    = ($urandom_range(0, 9) < 8);
            s_adv  = ($urandom_range(0, 9) < 8);
            s_fl   = ($urandom_range(0, 9) == 0);
            s_r1   = $urandom_range(0, 7);
            s_r2   = $urandom_range(0, 7);
            s_rd   = $urandom_range(0, 7);
            s_wen  = ($urandom_range(0, 9) < 7);
            s_lt   = $urandom_range(0, DEPTH - 1);
            s_lng  = ($urandom_range(0, 9) == 0);
            s_lwbv = ($urandom_range(0, 9) < 3);
            s_lwbr = $urandom_range(0, 7);
            step(1);
        end

        idle();
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
